instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the decode interface: owns the PC and issues word fetches to instruction memory.
- Presents each fetched instruction, with its PC, to the decoder/datapath through a valid/ready handshake.
- Accepts PC redirects from execute (taken branch, JAL, JALR) and discards any in-flight fetch made stale by a redirect.
- Sits between instruction memory and the opcode-driven control/decode stage.

Parameters:
- XLEN, 32, address and data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- imem_req_o  output  1  single-cycle fetch request pulse
- imem_addr_o  output  XLEN  fetch address; valid while imem_req_o=1
- imem_rvalid_i  input  1  fetch response valid; arrives at least 1 cycle after the request
- imem_rdata_i  input  XLEN  fetched instruction word
- instr_valid_o  output  1  instr_o/pc_o hold a valid instruction
- instr_ready_i  input  1  downstream accepts the instruction
- instr_o  output  XLEN  instruction word to decode; opcode is [6:0]
- pc_o  output  XLEN  PC of instr_o
- pc_plus4_o  output  XLEN  pc_o+4, used for JAL/JALR link
- redirect_i  input  1  execute requests a PC change
- redirect_pc_i  input  XLEN  redirect target
- fault_o  output  1  sticky misaligned-redirect fault

Behaviour:
- Reset (async assert, clocked release):
  - state=FETCH, pc=RESET_PC, drop=0, fault_o=0, instr_valid_o=0.
  - instr_o=32'h0000_0013 (NOP), imem_req_o=0 while reset is asserted.
- Exactly one outstanding fetch at a time.
- imem_addr_o = pc at all times; pc_o = pc; pc_plus4_o = pc+4, wrapping modulo 2^XLEN.
- FETCH:
  - imem_req_o = !redirect_i && !fault_o.
  - If the request is issued, go to WAIT next cycle.
- WAIT:
  - imem_req_o=0.
  - On imem_rvalid_i with drop=0: capture imem_rdata_i into instr_o, set instr_valid_o=1, go to HOLD.
  - On imem_rvalid_i with drop=1: discard the data, clear drop, go to FETCH.
  - A response that arrives while no request is outstanding (any state other than WAIT) is ignored.
- HOLD:
  - instr_valid_o=1; instr_o and pc_o stay stable until the handshake.
  - On instr_valid_o && instr_ready_i: pc<=pc+4, instr_valid_o<=0, go to FETCH.
- Redirect (redirect_i=1, any state, highest priority):
  - pc<=redirect_pc_i; instr_valid_o<=0 next cycle.
  - From FETCH or HOLD: go to FETCH.
  - From WAIT without a same-cycle response: set drop=1 and stay in WAIT.
  - From WAIT with a same-cycle response: discard the response and go to FETCH.
  - Redirect together with instr_ready_i in HOLD: the held instruction counts as consumed, and the redirect target wins over pc+4.
- Misaligned redirect (redirect_pc_i[1:0] != 0):
  - fault_o<=1, sticky until reset; pc still loads the target.
  - No further requests are issued; instr_valid_o stays 0.
  - An outstanding response is still drained and discarded.
- Throughput: 3 cycles per instruction minimum (FETCH, WAIT, HOLD with ready), plus memory latency beyond 1 cycle.
- All state updates on the rising edge of clk_i; all outputs are registered except imem_req_o and the combinational pc_plus4_o.

Decomposition:
- Shared package rv32_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, HOLD};
  - RV_NOP = 32'h0000_0013;
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), shared with the control decoder;
  - XLEN default.
- No sub-module needed. The PC register and FSM live in one module.

Test Plan:
- Reset release, memory returns 32'h00500093 one cycle after the request, instr_ready_i=1 -> imem_addr_o=0x0, then instr_valid_o=1 with instr_o=32'h00500093 and pc_o=0x0; next request at 0x4.
- instr_ready_i held low for 5 cycles in HOLD -> instr_o, pc_o and instr_valid_o stable; no imem_req_o pulses; pc advances only after ready.
- redirect_i with target 0x100 while in WAIT -> drop set; response data (32'hDEADBEEF) never appears on instr_o; next request at 0x100.
- redirect_i and instr_ready_i in the same HOLD cycle, target 0x40 -> next fetch at 0x40, not pc+4.
- Redirect to 0x102 -> fault_o=1 next cycle; no further imem_req_o; instr_valid_o=0 until rst_ni is asserted.
- rst_ni asserted mid-WAIT -> outputs immediately at reset values; a late imem_rvalid_i after release is ignored; first request at RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 fetch state, NOP encoding and opcode constants
package rv32_pkg;
  localparam int RV_XLEN = 32;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing single-outstanding word fetches and handing instructions to decode
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fault_o
);
  fetch_state_t state;
  logic [XLEN-1:0] pc;
  logic drop;
  assign imem_req_o = rst_ni && state == FETCH && !redirect_i && !fault_o;
  assign imem_addr_o = pc;
  assign pc_o = pc;
  assign pc_plus4_o = pc + XLEN'(4);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= FETCH;
      pc <= RESET_PC;
      drop <= 1'b0;
      fault_o <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o <= XLEN'(RV_NOP);
    end else if (redirect_i) begin
      pc <= redirect_pc_i;
      instr_valid_o <= 1'b0;
      fault_o <= fault_o | (redirect_pc_i[1:0] != 2'b00);
      state <= (state == WAIT && !imem_rvalid_i) ? WAIT : FETCH;
      drop <= state == WAIT && !imem_rvalid_i;
    end else begin
      case (state)
        FETCH: if (imem_req_o) state <= WAIT;
        WAIT: if (imem_rvalid_i) begin
          drop <= 1'b0;
          state <= drop ? FETCH : HOLD;
          instr_valid_o <= !drop;
          if (!drop) instr_o <= imem_rdata_i;
        end
        HOLD: if (instr_ready_i) begin
          pc <= pc + XLEN'(4);
          instr_valid_o <= 1'b0;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench with a transaction-level fetch model
module tb_instr_fetch_unit;
  import rv32_pkg::*;
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic imem_req_o, imem_rvalid_i, instr_valid_o, instr_ready_i, redirect_i, fault_o;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, pc_plus4_o, redirect_pc_i;
  int checks = 0;
  int passes = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  logic [31:0] m_pc, m_oaddr;
  bit m_out, m_stale, m_has, m_fault, in_rst, seen;
  int m_cnt, min_lat, max_lat;
  instr_fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_ni), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .fault_o(fault_o)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic do_reset();
    in_rst = 1'b1;
    rst_ni = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    #1;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, RV_NOP);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    m_pc = 32'h0;
    m_out = 0;
    m_stale = 0;
    m_has = 0;
    m_fault = 0;
    m_cnt = 0;
    q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_ni = 1'b1;
    in_rst = 1'b0;
  endtask
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc, input bit spur);
    bit rv, req_e;
    rv = (m_out && m_cnt == 0) || (!m_out && spur);
    instr_ready_i = rdy;
    redirect_i = redir;
    redirect_pc_i = rpc;
    imem_rvalid_i = rv;
    imem_rdata_i = m_out ? (m_stale ? 32'hDEADBEEF : mem_word(m_oaddr)) : $urandom;
    #1;
    req_e = !m_out && !m_has && !m_fault && !redir;
    chk("imem_req", 32'(imem_req_o), 32'(req_e));
    if (req_e) chk("imem_addr", imem_addr_o, m_pc);
    if (m_out && m_cnt > 0) m_cnt--;
    if (redir) begin
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) m_fault = 1;
      m_has = 0;
      if (m_out) begin
        if (rv) m_out = 0;
        else m_stale = 1;
      end
    end else if (req_e) begin
      m_out = 1;
      m_stale = 0;
      m_oaddr = m_pc;
      m_cnt = $urandom_range(max_lat, min_lat);
    end else if (m_out && rv) begin
      m_out = 0;
      if (!m_stale) begin
        m_has = 1;
        q.push_back('{m_oaddr, mem_word(m_oaddr)});
      end
    end else if (m_has && rdy) begin
      m_has = 0;
      m_pc += 32'd4;
    end
    @(negedge clk);
    #1;
  endtask
  task automatic wait_for(input bit want_has);
    int n = 0;
    while (!(want_has ? m_has : m_out) && n < 30) begin
      cycle(!want_has, 1'b0, '0, 1'b0);
      n++;
    end
    if (n >= 30) begin
      checks++;
      $display("FAIL wait_bound: got timeout expected %s", want_has ? "instr" : "request");
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (in_rst) seen = 0;
    else begin
      chk("instr_valid", 32'(instr_valid_o), 32'(m_has));
      chk("fault", 32'(fault_o), 32'(m_fault));
      if (instr_valid_o && !seen) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL scoreboard: got instr %h at pc %h expected no instruction", instr_o, pc_o);
        end else begin
          cur = q.pop_front();
          chk("pc", pc_o, cur.pc);
          chk("instr", instr_o, cur.ins);
          chk("pc_plus4", pc_plus4_o, cur.pc + 32'd4);
        end
        seen = 1;
      end else if (instr_valid_o) begin
        chk("instr_stable", instr_o, cur.ins);
        chk("pc_stable", pc_o, cur.pc);
      end else seen = 0;
    end
  end
  initial begin
    in_rst = 1'b1;
    min_lat = 0;
    max_lat = 0;
    #1;
    do_reset();
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b0);
    wait_for(1'b1);
    repeat (5) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    min_lat = 2;
    max_lat = 2;
    wait_for(1'b0);
    cycle(1'b1, 1'b1, 32'h100, 1'b0);
    min_lat = 0;
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b0);
    wait_for(1'b1);
    cycle(1'b1, 1'b1, 32'h40, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b0);
    min_lat = 1;
    max_lat = 3;
    wait_for(1'b0);
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b1);
    min_lat = 0;
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, $urandom_range(15) == 0, {$urandom_range(32'hFFFF), 2'b00},
            $urandom_range(3) == 0);
    min_lat = 2;
    max_lat = 2;
    wait_for(1'b0);
    cycle(1'b1, 1'b1, 32'h102, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'($urandom_range(1)), 1'b0, '0, 1'($urandom_range(1)));
    chk("fault_sticky", 32'(fault_o), 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
